vga_sync_decoder: RTL

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers raster position, qualifiers and lock status from incoming hsync/vsync
module vga_sync_decoder #(
   parameter int HSIZE          = 640,
   parameter int HFPORCH        = 16,
   parameter int HSYNC          = 96,
   parameter int HBPORCH        = 48,
   parameter int HSYNC_POSITIVE = 0,
   parameter int VSIZE          = 480,
   parameter int VFPORCH        = 10,
   parameter int VSYNC          = 2,
   parameter int VBPORCH        = 33,
   parameter int VSYNC_POSITIVE = 0,
   localparam int HTOTAL = HSIZE + HFPORCH + HSYNC + HBPORCH,
   localparam int VTOTAL = VSIZE + VFPORCH + VSYNC + VBPORCH,
   localparam int XW     = $clog2(HTOTAL),
   localparam int YW     = $clog2(VTOTAL)
) (
   input  logic          pixel_clk,
   input  logic          reset_n,
   input  logic          hsync,
   input  logic          vsync,
   output logic [XW-1:0] pixel_x,
   output logic [YW-1:0] pixel_y,
   output logic          line_start,
   output logic          frame_start,
   output logic          pixel_visible,
   output logic          locked,
   output logic          sync_error
);
   typedef enum logic [2:0] {UNLOCKED, H_ACQ, V_ACQ, V_CHECK, LOCKED} state_t;
   // raw level of each sync line while inactive; xor with it normalises to active-high
   localparam logic          H_IDLE  = HSYNC_POSITIVE == 0;
   localparam logic          V_IDLE  = VSYNC_POSITIVE == 0;
   localparam logic [XW-1:0] H_LOAD  = XW'(HSIZE + HFPORCH);
   localparam logic [XW-1:0] H_LAST  = XW'(HTOTAL - 1);
   localparam logic [XW-1:0] H_WIDTH = XW'(HSYNC);
   localparam logic [YW-1:0] V_LOAD  = YW'(VSIZE + VFPORCH);
   localparam logic [YW-1:0] V_LAST  = YW'(VTOTAL - 1);

   state_t state_q, state_d;
   logic hs1_q, hs1_d, hs2_q, hs2_d, vs1_q, vs1_d, vs2_q, vs2_d;
   logic [XW-1:0] hcount_q, hcount_d, hlen_q, hlen_d, h_adv;
   logic [YW-1:0] vcount_q, vcount_d, v_adv;
   logic line_start_q, line_start_d, frame_start_q, frame_start_d;
   logic visible_q, visible_d, sync_error_q, sync_error_d;
   logic h_now, h_edge, h_fall, v_edge, h_wrap, h_on, v_on, fault;

   always_comb begin
      hs1_d    = hsync;
      hs2_d    = hs1_q;
      vs1_d    = vsync;
      vs2_d    = vs1_q;
      h_now    = hs1_q ^ H_IDLE;
      h_edge   = h_now & ~(hs2_q ^ H_IDLE);
      h_fall   = ~h_now & (hs2_q ^ H_IDLE);
      v_edge   = (vs1_q ^ V_IDLE) & ~(vs2_q ^ V_IDLE);
      // where the counters would land without a sync load; edges are timed against this
      h_adv    = (hcount_q == H_LAST) ? '0 : hcount_q + 1'b1;
      h_wrap   = ~h_edge & (hcount_q == H_LAST);
      v_adv    = ~h_wrap ? vcount_q : (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
      h_on     = h_adv == H_LOAD;
      v_on     = v_adv == V_LOAD;
      hcount_d = h_edge ? H_LOAD : h_adv;
      vcount_d = v_edge ? V_LOAD : v_adv;
      hlen_d   = h_edge ? XW'(1) : (h_now && hlen_q != '1) ? hlen_q + 1'b1 : hlen_q;
      fault    = (h_edge & ~h_on) | (h_on & ~h_edge) | (v_edge & ~v_on) |
                 (h_fall & (hlen_q != H_WIDTH));
      state_d  = state_q;
      case (state_q)
         UNLOCKED: state_d = h_edge ? H_ACQ : UNLOCKED;
         H_ACQ:    state_d = !h_edge ? H_ACQ : h_on ? V_ACQ : UNLOCKED;
         V_ACQ:    state_d = (h_edge & ~h_on) ? UNLOCKED : v_edge ? V_CHECK : V_ACQ;
         V_CHECK:  state_d = (h_edge & ~h_on) ? UNLOCKED : !v_edge ? V_CHECK :
                             v_on ? LOCKED : UNLOCKED;
         LOCKED:   state_d = fault ? UNLOCKED : LOCKED;
         default:  state_d = UNLOCKED;
      endcase
      sync_error_d  = (state_q == LOCKED) & fault;
      line_start_d  = (state_d == LOCKED) & (hcount_d == '0);
      frame_start_d = line_start_d & (vcount_d == '0);
      visible_d     = (state_d == LOCKED) & (hcount_d < XW'(HSIZE)) & (vcount_d < YW'(VSIZE));
   end

   always_ff @(posedge pixel_clk) begin
      if (!reset_n) begin
         state_q       <= UNLOCKED;
         hs1_q         <= H_IDLE;
         hs2_q         <= H_IDLE;
         vs1_q         <= V_IDLE;
         vs2_q         <= V_IDLE;
         hcount_q      <= '0;
         vcount_q      <= '0;
         hlen_q        <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         visible_q     <= 1'b0;
         sync_error_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         hs1_q         <= hs1_d;
         hs2_q         <= hs2_d;
         vs1_q         <= vs1_d;
         vs2_q         <= vs2_d;
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         hlen_q        <= hlen_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         visible_q     <= visible_d;
         sync_error_q  <= sync_error_d;
      end
   end

   assign pixel_x       = hcount_q;
   assign pixel_y       = vcount_q;
   assign line_start    = line_start_q;
   assign frame_start   = frame_start_q;
   assign pixel_visible = visible_q;
   assign sync_error    = sync_error_q;
   assign locked        = state_q == LOCKED;
endmodule
